// File: rtl/decimal_entry_pkg.sv
// rtl/decimal_entry_pkg.sv - shared types and constants for the decimal entry block
package decimal_entry_pkg;

   localparam int VALUE_W    = 28;
   localparam int MAX_DIGITS = 8;
   localparam int COUNT_W    = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ENTRY = 2'd1,
      ST_READY = 2'd2
   } state_t;

   // value*10 + d built from shifts so no multiplier is inferred
   function automatic logic [VALUE_W-1:0] times10_plus(input logic [VALUE_W-1:0] v,
                                                       input logic [3:0]         d);
      logic [VALUE_W-1:0] d_ext;
      d_ext = {{(VALUE_W-4){1'b0}}, d};
      return (v << 3) + (v << 1) + d_ext;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronizer, debouncer and press-edge detector for one active-low key
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clock,
   input  logic resetn,
   input  logic key_n,
   output logic press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic             level;
   logic [CNT_W-1:0] cnt;

   // Two-flop synchronizer; idles released (high) so reset release makes no edge
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], key_n};
      end
   end

   // Flip the stable level after DEBOUNCE_CYCLES consecutive differing samples; pulse on the falling flip
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         level <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         press <= 1'b0;
         if (sync_q[1] == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync_q[1];
            cnt   <= '0;
            press <= ~sync_q[1];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/decimal_entry.sv
// rtl/decimal_entry.sv - debounced keypad decimal number entry with CPU handshake
module decimal_entry
   import decimal_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic [3:0]         digit_sw,
   input  logic               key_digit_n,
   input  logic               key_enter_n,
   input  logic               key_clear_n,
   output logic [VALUE_W-1:0] value,
   output logic [COUNT_W-1:0] digit_count,
   output logic               in_valid,
   input  logic               in_ack,
   output logic               entry_err
);

   logic ev_digit, ev_enter, ev_clear;

   state_t             state, state_n;
   logic [VALUE_W-1:0] value_n;
   logic [COUNT_W-1:0] count_n;
   logic               err_n;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_digit (
      .clock (clock), .resetn(resetn), .key_n(key_digit_n), .press(ev_digit)
   );
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_enter (
      .clock (clock), .resetn(resetn), .key_n(key_enter_n), .press(ev_enter)
   );
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clear (
      .clock (clock), .resetn(resetn), .key_n(key_clear_n), .press(ev_clear)
   );

   // State, value, count and error pulse registers
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state       <= ST_IDLE;
         value       <= '0;
         digit_count <= '0;
         entry_err   <= 1'b0;
      end else begin
         state       <= state_n;
         value       <= value_n;
         digit_count <= count_n;
         entry_err   <= err_n;
      end
   end

   // Event handling with priority clear > ack > enter > digit; READY freezes entry
   always_comb begin
      state_n = state;
      value_n = value;
      count_n = digit_count;
      err_n   = 1'b0;
      if (ev_clear) begin
         state_n = ST_IDLE;
         value_n = '0;
         count_n = '0;
      end else if (in_ack && state == ST_READY) begin
         state_n = ST_IDLE;
         count_n = '0;
      end else if (ev_enter && state != ST_READY) begin
         state_n = ST_READY;
         // IDLE still shows the previous committed value; an empty entry commits zero
         if (state == ST_IDLE) begin
            value_n = '0;
         end
      end else if (ev_digit && state != ST_READY) begin
         if (digit_sw > 4'd9 || digit_count == COUNT_W'(MAX_DIGITS)) begin
            err_n = 1'b1;
         end else begin
            state_n = ST_ENTRY;
            count_n = digit_count + 1'b1;
            if (state == ST_IDLE) begin
               value_n = {{(VALUE_W-4){1'b0}}, digit_sw};
            end else begin
               value_n = times10_plus(value, digit_sw);
            end
         end
      end
   end

   assign in_valid = (state == ST_READY);

endmodule

// File: tb/tb_decimal_entry.sv
// tb/tb_decimal_entry.sv - randomized self-checking bench for decimal_entry
module tb_decimal_entry;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic [3:0]  digit_sw = 4'd0;
   logic        key_digit_n = 1'b1;
   logic        key_enter_n = 1'b1;
   logic        key_clear_n = 1'b1;
   logic [27:0] value;
   logic [3:0]  digit_count;
   logic        in_valid;
   logic        in_ack = 1'b0;
   logic        entry_err;

   int checks = 0;
   int failures = 0;
   int err_seen = 0;

   // reference model state
   int m_value = 0;
   int m_count = 0;
   bit m_ready = 0;
   int m_err = 0;

   localparam bit [2:0] K_DIGIT = 3'b001;
   localparam bit [2:0] K_ENTER = 3'b010;
   localparam bit [2:0] K_CLEAR = 3'b100;

   decimal_entry #(.DEBOUNCE_CYCLES(4)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .digit_sw    (digit_sw),
      .key_digit_n (key_digit_n),
      .key_enter_n (key_enter_n),
      .key_clear_n (key_clear_n),
      .value       (value),
      .digit_count (digit_count),
      .in_valid    (in_valid),
      .in_ack      (in_ack),
      .entry_err   (entry_err)
   );

   always #5 clock = ~clock;

   // count error pulses, sampled away from the active edge
   always @(negedge clock) begin
      if (entry_err) err_seen++;
   end

   task automatic model_keys(input bit [2:0] mask, input int sw);
      if (mask[2]) begin
         m_value = 0; m_count = 0; m_ready = 0;
      end else if (m_ready) begin
      end else if (mask[1]) begin
         if (m_count == 0) m_value = 0;
         m_ready = 1;
      end else if (mask[0]) begin
         if (sw > 9 || m_count == 8) m_err++;
         else begin
            m_value = (m_count == 0) ? sw : m_value * 10 + sw;
            m_count++;
         end
      end
   endtask

   task automatic model_ack();
      if (m_ready) begin
         m_ready = 0; m_count = 0;
      end
   endtask

   task automatic press(input bit [2:0] mask, input int sw);
      @(negedge clock);
      digit_sw = 4'(sw);
      key_digit_n = ~mask[0];
      key_enter_n = ~mask[1];
      key_clear_n = ~mask[2];
      repeat (12) @(negedge clock);
      key_digit_n = 1'b1; key_enter_n = 1'b1; key_clear_n = 1'b1;
      repeat (12) @(negedge clock);
      model_keys(mask, sw);
   endtask

   task automatic ack();
      @(negedge clock);
      in_ack = 1'b1;
      @(negedge clock);
      in_ack = 1'b0;
      @(negedge clock);
      model_ack();
   endtask

   task automatic compare(input string tag);
      checks++;
      if (value !== 28'(m_value) || digit_count !== 4'(m_count) ||
          in_valid !== m_ready || err_seen != m_err) begin
         failures++;
         $display("FAIL %s: value=%0d count=%0d valid=%0b errs=%0d, expected value=%0d count=%0d valid=%0b errs=%0d",
                  tag, value, digit_count, in_valid, err_seen, m_value, m_count, m_ready, m_err);
      end
   endtask

   task automatic test_reset();
      checks++;
      if (value !== 28'd0 || digit_count !== 4'd0 || in_valid !== 1'b0 || entry_err !== 1'b0) begin
         failures++;
         $display("FAIL reset: value=%0d count=%0d valid=%0b err=%0b, expected all 0",
                  value, digit_count, in_valid, entry_err);
      end
   endtask

   task automatic test_basic();
      press(K_DIGIT, 1); press(K_DIGIT, 2); press(K_DIGIT, 3); press(K_DIGIT, 4);
      compare("basic_digits");
      press(K_ENTER, 0);
      checks++;
      if (value !== 28'd1234 || digit_count !== 4'd4 || in_valid !== 1'b1) begin
         failures++;
         $display("FAIL basic_enter: value=%0d count=%0d valid=%0b, expected 1234 4 1",
                  value, digit_count, in_valid);
      end
      ack();
      checks++;
      if (value !== 28'd1234 || in_valid !== 1'b0 || digit_count !== 4'd0) begin
         failures++;
         $display("FAIL basic_ack: value=%0d count=%0d valid=%0b, expected 1234 0 0",
                  value, digit_count, in_valid);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 8; i++) press(K_DIGIT, 9);
      press(K_DIGIT, 5);
      checks++;
      if (value !== 28'h5F5E0FF || digit_count !== 4'd8 || err_seen != m_err || m_err != 1) begin
         failures++;
         $display("FAIL overflow: value=%0h count=%0d errs=%0d, expected 5f5e0ff 8 1",
                  value, digit_count, err_seen);
      end
      press(K_CLEAR, 0);
      compare("overflow_clear");
   endtask

   task automatic test_bad_digit();
      press(K_DIGIT, 3);
      press(K_DIGIT, 12);
      compare("bad_digit");
      // bounce: 3 cycles low, then released
      @(negedge clock);
      digit_sw = 4'd6;
      key_digit_n = 1'b0;
      repeat (3) @(negedge clock);
      key_digit_n = 1'b1;
      repeat (15) @(negedge clock);
      compare("bounce_ignored");
   endtask

   task automatic test_clear_enter();
      press(K_DIGIT, 5); press(K_DIGIT, 6);
      press(K_CLEAR | K_ENTER, 0);
      checks++;
      if (value !== 28'd0 || digit_count !== 4'd0 || in_valid !== 1'b0) begin
         failures++;
         $display("FAIL clear_enter: value=%0d count=%0d valid=%0b, expected 0 0 0",
                  value, digit_count, in_valid);
      end
   endtask

   task automatic test_ready_ignore();
      press(K_DIGIT, 8);
      press(K_ENTER, 0);
      press(K_DIGIT, 7);
      compare("ready_digit_ignored");
      ack();
      press(K_DIGIT, 7);
      checks++;
      if (value !== 28'd7 || digit_count !== 4'd1) begin
         failures++;
         $display("FAIL after_ack_digit: value=%0d count=%0d, expected 7 1", value, digit_count);
      end
      // ack outside READY has no effect
      ack();
      compare("ack_outside_ready");
      press(K_ENTER, 0);
      ack();
      press(K_ENTER, 0);
      compare("empty_enter");
      ack();
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         int r;
         r = $urandom_range(0, 19);
         if (r < 12) press(K_DIGIT, $urandom_range(0, 11));
         else if (r < 15) press(K_ENTER, 0);
         else if (r < 17) ack();
         else if (r < 18) press(K_CLEAR, 0);
         else press(3'($urandom_range(1, 7)), $urandom_range(0, 9));
         compare("random");
      end
   endtask

   task automatic test_reset_mid();
      press(K_CLEAR, 0);
      press(K_DIGIT, 4); press(K_DIGIT, 2);
      compare("pre_reset_42");
      @(negedge clock);
      #2 resetn = 1'b0;
      #1;
      checks++;
      if (value !== 28'd0 || digit_count !== 4'd0 || in_valid !== 1'b0 || entry_err !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: value=%0d count=%0d valid=%0b, expected 0 0 0",
                  value, digit_count, in_valid);
      end
      m_value = 0; m_count = 0; m_ready = 0;
      repeat (3) @(negedge clock);
      resetn = 1'b1;
      repeat (20) @(negedge clock);
      compare("post_reset_quiet");
   endtask

   initial begin
      repeat (3) @(negedge clock);
      test_reset();
      resetn = 1'b1;
      repeat (3) @(negedge clock);
      test_reset();
      test_basic();
      test_overflow();
      test_bad_digit();
      test_clear_enter();
      test_ready_ignore();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
